// File: rtl/param_seq_alu.sv
// Registered EX-stage ALU: single-cycle arithmetic/logic ops plus an iterative
// shift-add unsigned multiplier behind a start/busy/done handshake.
module param_seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] BussA,
    input  logic [WIDTH-1:0] BussB,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] OutputHi,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             carry
);

    localparam int unsigned CNTW = $clog2(WIDTH) + 1;
    localparam int unsigned MSB  = WIDTH - 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t            state_q;
    logic [CNTW-1:0]   cnt_q;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  out_q;
    logic [WIDTH-1:0]  outhi_q;
    logic              busy_q;
    logic              done_q;
    logic              zero_q;
    logic              neg_q;
    logic              ovf_q;
    logic              cry_q;

    // Single-cycle datapath, evaluated on the live operands at the accept edge
    logic [WIDTH:0]    add_w;
    logic [WIDTH:0]    sub_w;
    logic              add_ovf;
    logic              sub_ovf;
    logic              slt_lt;
    logic              sltu_lt;
    logic [WIDTH-1:0]  res_c;
    logic              ovf_c;
    logic              cry_c;

    assign add_w   = {1'b0, BussA} + {1'b0, BussB};
    assign sub_w   = {1'b0, BussA} + {1'b0, ~BussB} + (WIDTH+1)'(1);
    assign add_ovf = (BussA[MSB] == BussB[MSB]) && (add_w[MSB] != BussA[MSB]);
    assign sub_ovf = (BussA[MSB] != BussB[MSB]) && (sub_w[MSB] != BussA[MSB]);
    assign slt_lt  = sub_w[MSB] ^ sub_ovf;
    assign sltu_lt = ~sub_w[WIDTH];

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        cry_c = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                res_c = add_w[WIDTH-1:0];
                ovf_c = add_ovf;
                cry_c = add_w[WIDTH];
            end
            OP_XOR:  res_c = BussA ^ BussB;
            OP_SUB: begin
                res_c = sub_w[WIDTH-1:0];
                ovf_c = sub_ovf;
                cry_c = sub_w[WIDTH];
            end
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_AND:  res_c = BussA & BussB;
            OP_OR:   res_c = BussA | BussB;
            OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, sltu_lt};
            default: res_c = '0;
        endcase
    end

    // One shift-add step: conditional add into the upper half, then shift the pair right
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]  mplier_d;
    logic              last_iter;

    assign mul_sum   = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_d     = mul_sum[WIDTH:1];
    assign mplier_d  = {mul_sum[0], mplier_q[WIDTH-1:1]};
    assign last_iter = (cnt_q == CNTW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            outhi_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cry_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (ALUControl == OP_MUL) begin
                            state_q  <= S_MUL;
                            busy_q   <= 1'b1;
                            mcand_q  <= BussA;
                            mplier_q <= BussB;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                        end else begin
                            out_q   <= res_c;
                            outhi_q <= '0;
                            done_q  <= 1'b1;
                            zero_q  <= (res_c == '0);
                            neg_q   <= res_c[MSB];
                            ovf_q   <= ovf_c;
                            cry_q   <= cry_c;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CNTW'(1);
                    if (last_iter) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= mplier_d;
                        outhi_q <= acc_d;
                        zero_q  <= ({acc_d, mplier_d} == '0);
                        neg_q   <= mplier_d[MSB];
                        ovf_q   <= 1'b0;
                        cry_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Output   = out_q;
    assign OutputHi = outhi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign zero     = zero_q;
    assign negative = neg_q;
    assign overflow = ovf_q;
    assign carry    = cry_q;

endmodule

// File: doc/param_seq_alu.md
Name: param_seq_alu

Overview:
- Parametrised, registered successor to the combinational 32-bit ALU in the five-stage MIPS datapath.
- Generalises the width, extends the op set to 8 operations and adds full status flags.
- Adds an iterative shift-add multiplier with a start/busy/done handshake.
- Sits in the EX stage. The hazard unit stalls the pipe while busy is high.

Parameters:
- WIDTH, 32: operand/result width in bits; legal range 4..64.
- CNTW, $clog2(WIDTH)+1: iteration counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only when busy=0.
- ALUControl  input  3  op select. 000 ADD, 001 XOR, 010 SUB, 011 SLT (signed), 100 AND, 101 OR, 110 SLTU, 111 MUL (unsigned).
- BussA  input  WIDTH  operand A.
- BussB  input  WIDTH  operand B.
- Output  output  WIDTH  result; low half of the product for MUL.
- OutputHi  output  WIDTH  high half of the product for MUL; 0 for all other ops.
- busy  output  1  high while a MUL is iterating.
- done  output  1  one-cycle pulse when Output and flags become valid.
- zero  output  1  result == 0. For MUL this is {OutputHi,Output} == 0.
- negative  output  1  Output[WIDTH-1].
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
- carry  output  1  carry-out for ADD; no-borrow (A >= B unsigned) for SUB; 0 otherwise.

Behaviour:
- Reset, synchronous, priority over everything:
  - State goes to IDLE; counter = 0.
  - Output, OutputHi, busy, done and all flags go to 0.
  - A MUL in progress is aborted. No done pulse is issued for it.
- States: IDLE, MUL.
- Accept: on an edge where start=1 and busy=0, BussA, BussB and ALUControl are latched internally. Operand changes after the accept edge have no effect.
- Single-cycle ops (000-110):
  - On the accept edge, Output, OutputHi (=0) and flags are registered. Latency is 1.
  - done=1 for exactly the following cycle.
  - State stays IDLE, so back-to-back starts each produce a result every cycle with done held high.
- SLT/SLTU: Output = {WIDTH-1 zeros, lt}. Signed lt = (A-B) sign XOR overflow.
- ADD/SUB: computed at WIDTH+1 bits. carry = bit WIDTH of A + B (ADD) or of A + ~B + 1 (SUB). overflow = operand signs agree (B inverted for SUB) and the result sign differs.
- MUL:
  - The accept edge enters MUL and sets busy=1. It loads multiplicand = A, multiplier = B, product accumulator = 0 and counter = 0.
  - Each cycle in MUL: if multiplier LSB = 1, add the multiplicand into the upper half. Then shift the {acc, multiplier} pair right by 1 and increment counter.
  - On the edge where counter reaches WIDTH-1 the last iteration completes, and:
    - {OutputHi, Output} are registered; state returns to IDLE.
    - busy goes to 0 and done=1 for one cycle.
  - Accept at edge k gives busy high during cycles k+1 .. k+WIDTH, with done on cycle k+WIDTH+1.
  - Flags for MUL: zero as defined above; negative = Output MSB; overflow = 0; carry = 0.
- Start while busy=1 is ignored and not queued. Output, OutputHi and flags keep their previous values until the MUL completes.
- Hold: between operations, Output, OutputHi and flags retain the last result. done is 0 in any cycle not directly following a completion.
- A new start in the done cycle is legal and accepted.
- Operands of 0 for MUL still take the full WIDTH iterations; no early exit.

Test Plan:
- WIDTH=32, ADD, A=32'h7FFFFFFF, B=1 -> next cycle: Output=32'h80000000, overflow=1, negative=1, carry=0, zero=0, done=1 for 1 cycle.
- WIDTH=32, SUB, A=5, B=5 -> Output=0, zero=1, carry=1, overflow=0. Then SLT A=-1 (32'hFFFFFFFF), B=1 -> Output=1. Then SLTU with the same operands -> Output=0.
- WIDTH=32, MUL, A=32'hFFFFFFFF, B=32'hFFFFFFFF -> busy high 32 cycles, done at accept+33. OutputHi=32'hFFFFFFFE, Output=32'h00000001, zero=0.
- WIDTH=8, MUL, A=8'd200, B=8'd3 -> busy for 8 cycles. {OutputHi,Output}=16'h0258. A start pulse issued mid-busy with ADD is ignored and the result is unchanged.
- WIDTH=32, MUL in progress, reset asserted at iteration 10 -> next edge: busy=0, done=0, Output=0, no late done pulse. A following XOR of A=32'hF0F0F0F0 with B=32'hFFFF0000 -> Output=32'h0F0FF0F0.
- Back-to-back single-cycle ops: ADD, AND, OR issued on 3 consecutive cycles -> done high for 3 consecutive cycles, each Output matching its op in order.
